// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side interface buffer.
package uart_pkg;
   localparam int TX_DATA_W_DEF = 8;
   localparam int OVF_CNT_W     = 8;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT, GUARD} tx_state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// Small circular FIFO for the transmit path; the head entry is presented combinationally on dout.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count <= r_count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign full  = (r_count == CW'(FIFO_DEPTH));
   assign empty = (r_count == '0);
endmodule

// File: rtl/uart_tx_interface.sv
// Producer-side transmit buffer: queues bytes and paces them into the UART TX core with a guard gap.
// Define UART_TX_OVF_CNT_EN to add the saturating ovf_count dropped-write counter port.
module uart_tx_interface
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = TX_DATA_W_DEF,
   parameter int FIFO_DEPTH   = 4,
   parameter int GUARD_CYCLES = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  tx_full,
   output logic                  tx_empty,
   output logic                  tx_busy,
   output logic                  tx_start,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_done
`ifdef UART_TX_OVF_CNT_EN
   ,
   output logic [OVF_CNT_W-1:0]  ovf_count
`endif
);
   localparam int GW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

   tx_state_e             r_state;
   logic [GW-1:0]         r_guard_cnt;
   logic [DATA_WIDTH-1:0] r_tx_data;
   logic                  r_tx_start;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_head;

   // Full is the pre-pop view, so a write on the popping edge of a full FIFO is still dropped.
   assign w_push = wr_en && !w_full;
   assign w_pop  = (r_state == IDLE) && !w_empty;

   uart_tx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (wr_data),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_guard_cnt <= '0;
         r_tx_data   <= '0;
         r_tx_start  <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_state    <= LOAD;
                  r_tx_data  <= w_head;
                  r_tx_start <= 1'b1;
               end
            end
            LOAD: r_state <= WAIT;
            WAIT: begin
               if (tx_done) begin
                  if (GUARD_CYCLES == 0) begin
                     r_state   <= IDLE;
                     r_tx_data <= '0;
                  end else begin
                     r_state     <= GUARD;
                     r_guard_cnt <= GW'(1);
                  end
               end
            end
            GUARD: begin
               if (r_guard_cnt == GW'(GUARD_CYCLES)) begin
                  r_state   <= IDLE;
                  r_tx_data <= '0;
               end else begin
                  r_guard_cnt <= r_guard_cnt + GW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign tx_busy  = (r_state != IDLE);
   assign tx_full  = w_full;
   assign tx_empty = w_empty;

`ifdef UART_TX_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] r_ovf_cnt;

   function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
      return (v == '1) ? v : v + OVF_CNT_W'(1);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset)              r_ovf_cnt <= '0;
      else if (wr_en && w_full) r_ovf_cnt <= sat_inc(r_ovf_cnt);
   end

   assign ovf_count = r_ovf_cnt;
`endif
endmodule

// File: tb/tb_uart_tx_interface.sv
// Self-checking bench for uart_tx_interface: vector table, directed corner sequences, randomized run against a timeline model.
module tb_uart_tx_interface;
   localparam int DEPTH = 4;
   localparam int G     = 3;
   localparam bit H = 1'b1;
   localparam bit L = 1'b0;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] wr_data, b_wr_data;
   logic       wr_en, tx_done, b_wr_en, b_tx_done;
   logic       tx_full, tx_empty, tx_busy, tx_start;
   logic [7:0] tx_data;
   logic       b_full, b_empty, b_busy, b_start;
   logic [7:0] b_data;
`ifdef UART_TX_OVF_CNT_EN
   logic [7:0] ovf_count, b_ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   uart_tx_interface #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .GUARD_CYCLES(G)) dut (
      .clock(clock), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
      .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
`ifdef UART_TX_OVF_CNT_EN
      , .ovf_count(ovf_count)
`endif
   );

   uart_tx_interface #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .GUARD_CYCLES(0)) dut_g0 (
      .clock(clock), .reset(reset), .wr_data(b_wr_data), .wr_en(b_wr_en),
      .tx_full(b_full), .tx_empty(b_empty), .tx_busy(b_busy),
      .tx_start(b_start), .tx_data(b_data), .tx_done(b_tx_done)
`ifdef UART_TX_OVF_CNT_EN
      , .ovf_count(b_ovf)
`endif
   );

   typedef struct {
      logic       we;
      logic [7:0] wd;
      logic       dn;
      logic       e_start;
      logic [7:0] e_data;
      logic       e_busy;
      logic       e_empty;
      logic       e_full;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(bit we, bit [7:0] wd, bit dn, bit s, bit [7:0] d, bit b, bit e, bit f);
      vec_t v;
      v.we = we; v.wd = wd; v.dn = dn;
      v.e_start = s; v.e_data = d; v.e_busy = b; v.e_empty = e; v.e_full = f;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Steps until tx_start is seen (bounded), then checks the byte offered to the core.
   task automatic wait_start(input logic [7:0] exp, input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step();
         seen = tx_start;
      end
      chk1({name, "_start_seen"}, seen, 1'b1);
      chk8({name, "_data"}, tx_data, exp);
   endtask

   // One cycle of margin moves the FSM from LOAD into WAIT before tx_done is presented.
   task automatic pulse_done();
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      logic idle;
      idle = !tx_busy;
      for (int i = 0; i < 30 && !idle; i++) begin
         step();
         idle = !tx_busy;
      end
      chk1({name, "_idle_reached"}, idle, 1'b1);
   endtask

   // Timeline model state for the randomized run.
   logic [7:0] q[$];
   logic       m_send;
   logic [7:0] m_data;
   int         m_start, m_done, m_ovf, n;

   initial begin
      int starts;
      logic m_st;
      int pre;

      reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
      b_wr_en = 1'b0; b_wr_data = 8'h00; b_tx_done = 1'b0;
      step(); step();
      chk1("rst_start", tx_start, 1'b0);
      chk8("rst_data", tx_data, 8'h00);
      chk1("rst_full", tx_full, 1'b0);
      chk1("rst_empty", tx_empty, 1'b1);
      chk1("rst_busy", tx_busy, 1'b0);
`ifdef UART_TX_OVF_CNT_EN
      chk8("rst_ovf", ovf_count, 8'h00);
`endif
      reset = 1'b0;
      step();

      // Single byte with guard timing, then tx_done during LOAD being ignored.
      tbl[0]  = mk(H, 8'hA5, L,  L, 8'h00, L, L, L);
      tbl[1]  = mk(L, 8'h00, L,  H, 8'hA5, H, H, L);
      tbl[2]  = mk(L, 8'h00, L,  L, 8'hA5, H, H, L);
      tbl[3]  = mk(L, 8'h00, L,  L, 8'hA5, H, H, L);
      tbl[4]  = mk(L, 8'h00, L,  L, 8'hA5, H, H, L);
      tbl[5]  = mk(L, 8'h00, H,  L, 8'hA5, H, H, L);
      tbl[6]  = mk(L, 8'h00, L,  L, 8'hA5, H, H, L);
      tbl[7]  = mk(L, 8'h00, L,  L, 8'hA5, H, H, L);
      tbl[8]  = mk(L, 8'h00, L,  L, 8'h00, L, H, L);
      tbl[9]  = mk(L, 8'h00, L,  L, 8'h00, L, H, L);
      tbl[10] = mk(H, 8'h3C, L,  L, 8'h00, L, L, L);
      tbl[11] = mk(L, 8'h00, L,  H, 8'h3C, H, H, L);
      tbl[12] = mk(L, 8'h00, H,  L, 8'h3C, H, H, L);
      tbl[13] = mk(L, 8'h00, L,  L, 8'h3C, H, H, L);
      tbl[14] = mk(L, 8'h00, L,  L, 8'h3C, H, H, L);
      tbl[15] = mk(L, 8'h00, H,  L, 8'h3C, H, H, L);
      tbl[16] = mk(L, 8'h00, L,  L, 8'h3C, H, H, L);
      tbl[17] = mk(L, 8'h00, L,  L, 8'h3C, H, H, L);
      tbl[18] = mk(L, 8'h00, L,  L, 8'h00, L, H, L);
      for (int i = 0; i < 19; i++) begin
         wr_en = tbl[i].we; wr_data = tbl[i].wd; tx_done = tbl[i].dn;
         step();
         chk1($sformatf("tbl%0d_start", i), tx_start, tbl[i].e_start);
         chk8($sformatf("tbl%0d_data", i), tx_data, tbl[i].e_data);
         chk1($sformatf("tbl%0d_busy", i), tx_busy, tbl[i].e_busy);
         chk1($sformatf("tbl%0d_empty", i), tx_empty, tbl[i].e_empty);
         chk1($sformatf("tbl%0d_full", i), tx_full, tbl[i].e_full);
      end
      wr_en = 1'b0; tx_done = 1'b0;

      // Overflow while stalled in WAIT: fifth write dropped, order preserved.
      wr_en = 1'b1; wr_data = 8'h10; step(); wr_en = 1'b0;
      wait_start(8'h10, "ovf_first");
      step();
      for (int i = 1; i <= 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(i); step();
      end
      wr_en = 1'b0;
      chk1("ovf_full", tx_full, 1'b1);
      chk1("ovf_busy", tx_busy, 1'b1);
`ifdef UART_TX_OVF_CNT_EN
      chk8("ovf_count1", ovf_count, 8'd1);
`endif
      for (int i = 1; i <= 4; i++) begin
         pulse_done();
         wait_start(8'(i), $sformatf("ovf_order%0d", i));
      end

      // Full FIFO in IDLE with a write on the popping edge.
      step();
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_data = 8'h61 + 8'(i); step();
      end
      wr_en = 1'b0;
      chk1("fp_full_before", tx_full, 1'b1);
      tx_done = 1'b1; step(); tx_done = 1'b0;
      wait_idle("fp");
      chk1("fp_full_idle", tx_full, 1'b1);
      wr_en = 1'b1; wr_data = 8'h77; step(); wr_en = 1'b0;
      chk1("fp_pop_start", tx_start, 1'b1);
      chk8("fp_pop_data", tx_data, 8'h61);
      chk1("fp_full_after", tx_full, 1'b0);
      chk1("fp_empty_after", tx_empty, 1'b0);
`ifdef UART_TX_OVF_CNT_EN
      chk8("fp_ovf_count2", ovf_count, 8'd2);
`endif
      for (int i = 1; i < 4; i++) begin
         pulse_done();
         wait_start(8'h61 + 8'(i), $sformatf("fp_drain%0d", i));
      end
      pulse_done();
      wait_idle("fp_end");
      starts = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tx_start) starts++;
      end
      chk8("fp_no_0x77", 8'(starts), 8'd0);
      chk1("fp_empty_end", tx_empty, 1'b1);

      // Asynchronous reset mid-WAIT with two bytes queued.
      wr_en = 1'b1; wr_data = 8'h50; step(); wr_en = 1'b0;
      wait_start(8'h50, "rw_first");
      step();
      wr_en = 1'b1; wr_data = 8'h88; step();
      wr_data = 8'h99; step(); wr_en = 1'b0;
      chk1("rw_queued", tx_empty, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk1("rw_start", tx_start, 1'b0);
      chk8("rw_data", tx_data, 8'h00);
      chk1("rw_full", tx_full, 1'b0);
      chk1("rw_empty", tx_empty, 1'b1);
      chk1("rw_busy", tx_busy, 1'b0);
`ifdef UART_TX_OVF_CNT_EN
      chk8("rw_ovf", ovf_count, 8'd0);
`endif
      step(); step();
      reset = 1'b0;
      starts = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tx_start) starts++;
      end
      chk8("rw_no_start", 8'(starts), 8'd0);

      // GUARD_CYCLES=0 instance: tx_done returns straight to IDLE, next byte one edge later.
      b_wr_en = 1'b1; b_wr_data = 8'hB1; step();
      b_wr_data = 8'hB2; step(); b_wr_en = 1'b0;
      chk1("g0_start1", b_start, 1'b1);
      chk8("g0_data1", b_data, 8'hB1);
      step();
      b_tx_done = 1'b1; step(); b_tx_done = 1'b0;
      chk1("g0_idle_busy", b_busy, 1'b0);
      chk8("g0_idle_data", b_data, 8'h00);
      chk1("g0_idle_start", b_start, 1'b0);
      step();
      chk1("g0_start2", b_start, 1'b1);
      chk8("g0_data2", b_data, 8'hB2);
      step();
      chk1("g0_start2_end", b_start, 1'b0);
      b_tx_done = 1'b1; step(); b_tx_done = 1'b0;

      // Randomized traffic against a timeline model of the queue and transfer windows.
      reset = 1'b1; step(); reset = 1'b0;
      q.delete();
      m_send = 1'b0; m_data = 8'h00; m_start = 0; m_done = -1; m_ovf = 0; n = 0;
      for (int c = 0; c < 600; c++) begin
         wr_en   = ($urandom_range(0, 1) == 1);
         wr_data = 8'($urandom);
         tx_done = ($urandom_range(0, 4) == 0);
         pre  = q.size();
         m_st = 1'b0;
         if (!m_send && pre > 0) begin
            m_st = 1'b1; m_data = q.pop_front(); m_send = 1'b1; m_start = n; m_done = -1;
         end else if (m_send && m_done < 0 && tx_done && n >= m_start + 2) begin
            m_done = n;
         end
         if (m_send && m_done >= 0 && n == m_done + G) begin
            m_send = 1'b0; m_data = 8'h00;
         end
         if (wr_en) begin
            if (pre == DEPTH) m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
            else q.push_back(wr_data);
         end
         step();
         n++;
         chk1($sformatf("rnd%0d_start", c), tx_start, m_st);
         chk8($sformatf("rnd%0d_data", c), tx_data, m_data);
         chk1($sformatf("rnd%0d_busy", c), tx_busy, m_send);
         chk1($sformatf("rnd%0d_full", c), tx_full, q.size() == DEPTH);
         chk1($sformatf("rnd%0d_empty", c), tx_empty, q.size() == 0);
`ifdef UART_TX_OVF_CNT_EN
         chk8($sformatf("rnd%0d_ovf", c), ovf_count, 8'(m_ovf));
`endif
      end
      wr_en = 1'b0; tx_done = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
